secded_rmw_encoder: RTL and testbench

- Write-side companion of the Hsiao (39,32) SECDED analyzer; sits between a core/bus store port and an ECC-protected 39-bit SRAM.
- Encodes 32-bit store data into a 39-bit codeword and writes it to the SRAM.
- Partial (byte-enable) stores use a read-modify-write sequence: read the old word, check it and correct a single-bit error, merge the new bytes, re-encode, then write.

---
 rtl/secded_rmw_encoder.sv | 170 +++++++++++++++++
 tb/tb_secded_rmw_encoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/secded_rmw_encoder.sv
// Hsiao (39,32) SECDED write path: full stores are encoded directly, partial stores
// read the old word, correct a single-bit error, merge the new bytes and re-encode.
module secded_rmw_encoder #(
    parameter int AW = 10,
    parameter int DW = 32,
    parameter int CW = 7
) (
    input  logic               s_clk_i,
    input  logic               s_reset_i,
    input  logic               s_req_val_i,
    output logic               s_req_rdy_o,
    input  logic [AW-1:0]      s_req_addr_i,
    input  logic [DW-1:0]      s_req_wdata_i,
    input  logic [3:0]         s_req_be_i,
    output logic               s_mem_req_o,
    output logic               s_mem_we_o,
    output logic [AW-1:0]      s_mem_addr_o,
    output logic [DW+CW-1:0]   s_mem_wdata_o,
    input  logic [DW+CW-1:0]   s_mem_rdata_i,
    output logic               s_done_o,
    output logic               s_ce_o,
    output logic               s_uce_o
);

    // Data columns: the first 32 weight-3 vectors in ascending order
    localparam logic [CW-1:0] H_COL [32] = '{
        7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19,
        7'h1A, 7'h1C, 7'h23, 7'h25, 7'h26, 7'h29, 7'h2A, 7'h2C,
        7'h31, 7'h32, 7'h34, 7'h38, 7'h43, 7'h45, 7'h46, 7'h49,
        7'h4A, 7'h4C, 7'h51, 7'h52, 7'h54, 7'h58, 7'h61, 7'h62
    };

    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DW; i++) begin
            if (d[i]) c ^= H_COL[i];
        end
        return c;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CHK,
        WR
    } state_t;

    state_t             state;
    logic [AW-1:0]      addr_q;
    logic [DW-1:0]      wdata_q;
    logic [3:0]         be_q;
    logic               rdy_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [DW+CW-1:0]   mem_wdata_q;
    logic               done_q;
    logic               ce_q;
    logic               uce_q;

    logic [CW-1:0]      syndrome;
    logic [DW-1:0]      flip;
    logic               col_hit;
    logic [DW-1:0]      corrected;
    logic               is_ce;
    logic               is_uce;
    logic [DW-1:0]      merged;

    // A syndrome matching a data column is always weight 3, so a hit covers that case
    always_comb begin
        syndrome = encode(s_mem_rdata_i[DW-1:0]) ^ s_mem_rdata_i[DW+CW-1:DW];
        flip     = '0;
        col_hit  = 1'b0;
        for (int i = 0; i < DW; i++) begin
            if (syndrome == H_COL[i]) begin
                flip[i] = 1'b1;
                col_hit = 1'b1;
            end
        end
        corrected = s_mem_rdata_i[DW-1:0] ^ flip;
        is_ce     = col_hit | $onehot(syndrome);
        is_uce    = (syndrome != '0) & ~is_ce;
        merged    = '0;
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : corrected[8*k +: 8];
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rdy_q       <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            ce_q        <= 1'b0;
            uce_q       <= 1'b0;
        end else begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            ce_q        <= 1'b0;
            uce_q       <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_req_val_i && rdy_q) begin
                        addr_q  <= s_req_addr_i;
                        wdata_q <= s_req_wdata_i;
                        be_q    <= s_req_be_i;
                        if (s_req_be_i == 4'hF) begin
                            state       <= WR;
                            rdy_q       <= 1'b0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= {encode(s_req_wdata_i), s_req_wdata_i};
                            done_q      <= 1'b1;
                        end else if (s_req_be_i == 4'h0) begin
                            done_q <= 1'b1;
                        end else begin
                            state     <= RD;
                            rdy_q     <= 1'b0;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state <= CHK;
                end
                CHK: begin
                    if (is_uce) begin
                        state  <= IDLE;
                        rdy_q  <= 1'b1;
                        done_q <= 1'b1;
                        uce_q  <= 1'b1;
                    end else begin
                        state       <= WR;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= {encode(merged), merged};
                        done_q      <= 1'b1;
                        ce_q        <= is_ce;
                    end
                end
                WR: begin
                    state <= IDLE;
                    rdy_q <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

    assign s_req_rdy_o   = rdy_q;
    assign s_mem_req_o   = mem_req_q;
    assign s_mem_we_o    = mem_we_q;
    assign s_mem_addr_o  = addr_q;
    assign s_mem_wdata_o = mem_wdata_q;
    assign s_done_o      = done_q;
    assign s_ce_o        = ce_q;
    assign s_uce_o       = uce_q;

endmodule

// File: tb/tb_secded_rmw_encoder.sv
// Directed bench for secded_rmw_encoder: hand-computed codewords and cycle-exact
// handshake checks against a small read-only SRAM image.
module tb_secded_rmw_encoder;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_val;
    logic          req_rdy;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_be;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [38:0]   mem_wdata;
    logic [38:0]   mem_rdata;
    logic          done;
    logic          ce;
    logic          uce;

    logic [38:0]   rd_image [1024];
    int            write_count = 0;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    secded_rmw_encoder #(.AW(AW), .DW(32), .CW(7)) dut (
        .s_clk_i       (clk),
        .s_reset_i     (reset),
        .s_req_val_i   (req_val),
        .s_req_rdy_o   (req_rdy),
        .s_req_addr_i  (req_addr),
        .s_req_wdata_i (req_wdata),
        .s_req_be_i    (req_be),
        .s_mem_req_o   (mem_req),
        .s_mem_we_o    (mem_we),
        .s_mem_addr_o  (mem_addr),
        .s_mem_wdata_o (mem_wdata),
        .s_mem_rdata_i (mem_rdata),
        .s_done_o      (done),
        .s_ce_o        (ce),
        .s_uce_o       (uce)
    );

    // SRAM model: read data one cycle after the strobe, writes only counted
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) write_count <= write_count + 1;
            else        mem_rdata   <= rd_image[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns at the falling edge of cycle N+1, N being the acceptance cycle
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        req_val   = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        req_be    = be;
        @(posedge clk);
        @(negedge clk);
        req_val = 1'b0;
    endtask

    task automatic checkFullWrite(input string tag, input logic [AW-1:0] addr, input logic [31:0] data,
                                  input logic [38:0] exp_cw);
        applyStimulus(addr, data, 4'hF);
        checkOutput({tag, "_req"},   mem_req,   1);
        checkOutput({tag, "_we"},    mem_we,    1);
        checkOutput({tag, "_addr"},  mem_addr,  addr);
        checkOutput({tag, "_wdata"}, mem_wdata, exp_cw);
        checkOutput({tag, "_done"},  done,      1);
        checkOutput({tag, "_ce"},    ce,        0);
        checkOutput({tag, "_uce"},   uce,       0);
        checkOutput({tag, "_rdy1"},  req_rdy,   0);
        @(negedge clk);
        checkOutput({tag, "_rdy2"},  req_rdy,   1);
        checkOutput({tag, "_req2"},  mem_req,   0);
        checkOutput({tag, "_wd2"},   mem_wdata, 0);
    endtask

    // Partial store whose read is correctable or clean; write lands at N+3
    task automatic checkPartial(input string tag, input logic [AW-1:0] addr, input logic [31:0] data,
                                input logic [3:0] be, input logic [38:0] exp_cw, input logic exp_ce);
        applyStimulus(addr, data, be);
        checkOutput({tag, "_rd_req"},  mem_req,  1);
        checkOutput({tag, "_rd_we"},   mem_we,   0);
        checkOutput({tag, "_rd_addr"}, mem_addr, addr);
        checkOutput({tag, "_rd_done"}, done,     0);
        @(negedge clk);
        checkOutput({tag, "_chk_req"}, mem_req,  0);
        checkOutput({tag, "_chk_rdy"}, req_rdy,  0);
        @(negedge clk);
        checkOutput({tag, "_wr_req"},  mem_req,   1);
        checkOutput({tag, "_wr_we"},   mem_we,    1);
        checkOutput({tag, "_wr_addr"}, mem_addr,  addr);
        checkOutput({tag, "_wdata"},   mem_wdata, exp_cw);
        checkOutput({tag, "_done"},    done,      1);
        checkOutput({tag, "_ce"},      ce,        exp_ce);
        checkOutput({tag, "_uce"},     uce,       0);
        @(negedge clk);
        checkOutput({tag, "_rdy"},     req_rdy,   1);
    endtask

    task automatic checkUncorrectable(input string tag, input logic [AW-1:0] addr);
        int w0;
        w0 = write_count;
        applyStimulus(addr, 32'hDEADBEEF, 4'b0100);
        checkOutput({tag, "_rd_req"}, mem_req, 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput({tag, "_req"},  mem_req, 0);
        checkOutput({tag, "_done"}, done,    1);
        checkOutput({tag, "_uce"},  uce,     1);
        checkOutput({tag, "_ce"},   ce,      0);
        checkOutput({tag, "_rdy"},  req_rdy, 1);
        @(negedge clk);
        checkOutput({tag, "_nowr"}, write_count, w0);
        checkOutput({tag, "_done2"}, done,   0);
    endtask

    initial begin
        int w0;
        reset     = 1'b1;
        req_val   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rd_image[8]  = {7'h19, 32'h12345600};
        rd_image[9]  = {7'h00, 32'h00000002};
        rd_image[10] = {7'h00, 32'h00000003};
        rd_image[11] = {7'h01, 32'h00000000};
        rd_image[12] = {7'h64, 32'h00000000};
        rd_image[13] = {7'h00, 32'h00000000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_rdy",  req_rdy, 1);
        checkOutput("rst_req",  mem_req, 0);
        checkOutput("rst_done", done,    0);
        checkOutput("rst_ce",   ce,      0);
        checkOutput("rst_uce",  uce,     0);

        checkFullWrite("full1", 10'd5, 32'h00000001, 39'h07_00000001);
        checkFullWrite("full3", 10'd6, 32'h00000003, 39'h0C_00000003);
        checkFullWrite("full0", 10'd7, 32'h00000000, 39'h00_00000000);

        checkPartial("pclean", 10'd8,  32'h000000AB, 4'b0001, 39'h17_123456AB, 1'b0);
        checkPartial("pdata1", 10'd9,  32'h0000FF00, 4'b0010, 39'h09_0000FF00, 1'b1);
        checkPartial("pchkbit", 10'd11, 32'h00000055, 4'b0001, 39'h0F_00000055, 1'b1);

        checkUncorrectable("dbl",    10'd10);
        checkUncorrectable("unused", 10'd12);

        // Reset lands while the RMW is in its check cycle
        w0 = write_count;
        applyStimulus(10'd13, 32'h00000011, 4'b0001);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrst_rdy",  req_rdy, 1);
        checkOutput("midrst_done", done,    0);
        checkOutput("midrst_req",  mem_req, 0);
        @(negedge clk);
        checkOutput("midrst_req2", mem_req, 0);
        checkOutput("midrst_done2", done,   0);
        checkOutput("midrst_nowr", write_count, w0);

        w0 = write_count;
        applyStimulus(10'd20, 32'hCAFEF00D, 4'h0);
        checkOutput("be0_done", done,    1);
        checkOutput("be0_req",  mem_req, 0);
        checkOutput("be0_ce",   ce,      0);
        checkOutput("be0_uce",  uce,     0);
        checkOutput("be0_rdy",  req_rdy, 1);
        @(negedge clk);
        checkOutput("be0_done2", done,   0);
        checkOutput("be0_nowr", write_count, w0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
